// File: rtl/uart_fifo.sv
// First-word-fall-through byte FIFO between the host bus and the UART controller.
// The occupancy counter is kept separately from the pointers, and every status flag is decoded from it.
module uart_fifo #(
  parameter int DATA_W        = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              underflow;
  logic              push_ok;
  logic              pop_ok;

  assign full_o         = (level == LW'(DEPTH));
  assign empty_o        = (level == '0);
  assign almost_full_o  = (level >= LW'(AFULL_THRESH));
  assign almost_empty_o = (level <= LW'(AEMPTY_THRESH));
  assign level_o        = level;
  assign overflow_o     = overflow;
  assign underflow_o    = underflow;
  assign pop_data_o     = mem[rd_ptr];

  // A full FIFO can still take a push when a pop frees the head entry in the same cycle.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_i);

  // NOTE: the array is reset so that pop_data_o reads 0 after reset; a flush leaves it untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok && !clear_i) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (push_i && full_o && !pop_i) overflow  <= 1'b1;
      if (pop_i && empty_o)           underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: a directed vector table, hand-written corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_uart_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AFULL  = 12;
  localparam int AEMPTY = 2;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              clear_i;
  logic              push_i;
  logic [DATA_W-1:0] push_data_i;
  logic              pop_i;
  logic [DATA_W-1:0] pop_data_o;
  logic              full_o;
  logic              empty_o;
  logic              almost_full_o;
  logic              almost_empty_o;
  logic [4:0]        level_o;
  logic              overflow_o;
  logic              underflow_o;

  uart_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .push_i(push_i),
    .push_data_i(push_data_i), .pop_i(pop_i), .pop_data_o(pop_data_o),
    .full_o(full_o), .empty_o(empty_o), .almost_full_o(almost_full_o),
    .almost_empty_o(almost_empty_o), .level_o(level_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a plain queue of bytes plus the two sticky flags.
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_unf;

  typedef struct {
    logic       clear;
    logic       push;
    logic [7:0] data;
    logic       pop;
    int         exp_level;
    logic       exp_unf;
    logic [7:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic model_step(input logic c, input logic p, input logic [7:0] d, input logic po);
    int  sz;
    bit  take_pop;
    bit  take_push;
    if (c) begin
      model_reset();
      return;
    end
    sz        = q.size();
    take_pop  = po && sz > 0;
    take_push = p && (sz < DEPTH || po);
    if (po && sz == 0)           m_unf = 1;
    if (p && sz == DEPTH && !po) m_ovf = 1;
    if (take_pop)  void'(q.pop_front());
    if (take_push) q.push_back(d);
  endtask

  // One clock: drive inputs, take the edge, update the model, settle 1 ns after the edge.
  task automatic drive(input logic c, input logic p, input logic [7:0] d, input logic po);
    clear_i     = c;
    push_i      = p;
    push_data_i = d;
    pop_i       = po;
    @(posedge clk_i);
    model_step(c, p, d, po);
    #1;
    clear_i = 1'b0;
    push_i  = 1'b0;
    pop_i   = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    int sz;
    sz = q.size();
    check({tag, ".level"}, 32'(level_o), 32'(sz));
    check({tag, ".flags"},
          {26'd0, full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o},
          {26'd0, sz == DEPTH, sz == 0, sz >= AFULL, sz <= AEMPTY, m_ovf, m_unf});
    if (sz > 0) check({tag, ".data"}, 32'(pop_data_o), 32'(q[0]));
  endtask

  vec_t vecs[8];

  initial begin
    rst_ni      = 1'b0;
    clear_i     = 1'b0;
    push_i      = 1'b0;
    push_data_i = '0;
    pop_i       = 1'b0;
    model_reset();
    #12;
    check("reset.level", 32'(level_o), 0);
    check("reset.flags",
          {26'd0, full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o},
          32'b010100);
    check("reset.data", 32'(pop_data_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed table: push/pop, pop on empty, push+pop on empty, clear with push.
    vecs[0] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1, 1'b0, 8'hA5};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 8'h3C, 1'b1, 1, 1'b1, 8'h3C};
    vecs[4] = '{1'b0, 1'b1, 8'h11, 1'b0, 2, 1'b1, 8'h3C};
    vecs[5] = '{1'b1, 1'b1, 8'h22, 1'b0, 0, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 8'h77, 1'b0, 1, 1'b0, 8'h77};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].clear, vecs[i].push, vecs[i].data, vecs[i].pop);
      check($sformatf("vec%0d.level", i), 32'(level_o), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d.empty", i), 32'(empty_o), 32'(vecs[i].exp_level == 0));
      check($sformatf("vec%0d.underflow", i), 32'(underflow_o), 32'(vecs[i].exp_unf));
      if (vecs[i].exp_level > 0)
        check($sformatf("vec%0d.data", i), 32'(pop_data_o), 32'(vecs[i].exp_data));
    end

    // Fill to full, watch almost_full switch at 12, overflow, then drain in order.
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 8'(i), 1'b0);
      check($sformatf("fill%0d.afull", i), 32'(almost_full_o), 32'((i + 1) >= AFULL));
    end
    check("fill.full", 32'(full_o), 1);
    drive(1'b0, 1'b1, 8'hFF, 1'b0);
    check("ovf.flag", 32'(overflow_o), 1);
    check("ovf.level", 32'(level_o), 16);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain%0d.data", i), 32'(pop_data_o), 32'(i));
      drive(1'b0, 1'b0, 8'h00, 1'b1);
    end
    check("drain.empty", 32'(empty_o), 1);
    check("drain.ovf_sticky", 32'(overflow_o), 1);

    // Full FIFO with 20 cycles of simultaneous push+pop, wrapping both pointers.
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 8'(i), 1'b0);
    for (int k = 0; k < 20; k++) begin
      check($sformatf("wrap%0d.data", k), 32'(pop_data_o),
            (k < DEPTH) ? 32'(k) : 32'(8'h40 + k - DEPTH));
      drive(1'b0, 1'b1, 8'(8'h40 + k), 1'b1);
      check($sformatf("wrap%0d.lvl_full_ovf", k), {full_o, overflow_o, level_o}, {1'b1, 1'b0, 5'd16});
    end

    // Asynchronous reset pulse in the middle of a clock period.
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'(8'h90 + i), 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    model_reset();
    check("arst.level", 32'(level_o), 0);
    check("arst.flags",
          {26'd0, full_o, empty_o, almost_full_o, almost_empty_o, overflow_o, underflow_o},
          32'b010100);
    check("arst.data", 32'(pop_data_o), 0);
    #1 rst_ni = 1'b1;
    drive(1'b0, 1'b1, 8'h5A, 1'b0);
    compare_model("post_rst");

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic c, p, po;
      c  = ($urandom_range(0, 63) == 0);
      p  = ($urandom_range(0, 99) < ((n / 100) % 2 ? 70 : 40));
      po = ($urandom_range(0, 99) < ((n / 100) % 2 ? 40 : 65));
      drive(c, p, 8'($urandom), po);
      compare_model($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
